// File: rtl/scr1_reset_seq_ctrl_pkg.sv
// rtl/scr1_reset_seq_ctrl_pkg.sv - shared types and constants for the reset sequencer
//
// Purpose: sequencer state encoding and reset-cause bit positions, used by the RTL
//          and by software-facing code that decodes rst_cause.
// Ports:   none (package).
package scr1_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT    = 3'd0,
    ST_HOLD      = 3'd1,
    ST_WAIT_SYS  = 3'd2,
    ST_GAP       = 3'd3,
    ST_WAIT_CORE = 3'd4,
    ST_RUN       = 3'd5
  } type_scr1_rst_seq_state_e;

  // Bit positions inside rst_req / rst_cause
  localparam int SCR1_RST_SRC_EXT = 0;
  localparam int SCR1_RST_SRC_WDT = 1;
  localparam int SCR1_RST_SRC_DBG = 2;
  localparam int SCR1_RST_SRC_SW  = 3;

endpackage

// File: rtl/scr1_reset_seq_ctrl_if.sv
// rtl/scr1_reset_seq_ctrl_if.sv - request/status/reset bundle of the reset sequencer
//
// Purpose: groups every non-clock signal of the sequencer.
// Modports:
//   master - request side: drives rst_req, status feedback and rst_cause_clr,
//            observes the staged resets and the sticky flags
//   slave  - the sequencer itself
// Signals:
//   rst_req[NUM_SRC]   level reset requests (synchronised, active-high)
//   sys_rst_status     system buffer cell out of reset
//   core_rst_status    core buffer cell out of reset
//   rst_cause_clr      clears sticky cause / por_flag / seq_err while running
//   sys_rst_n_out      staged system reset, active-low
//   core_rst_n_out     staged core reset, active-low
//   seq_busy           sequence still in progress
//   rst_cause[NUM_SRC] sticky OR of all requests seen
//   por_flag           sticky power-on / hard reset indicator
//   seq_err            sticky status-wait timeout
interface scr1_reset_seq_ctrl_if #(
  parameter int NUM_SRC = 4
);
  logic [NUM_SRC-1:0] rst_req;
  logic               sys_rst_status;
  logic               core_rst_status;
  logic               rst_cause_clr;
  logic               sys_rst_n_out;
  logic               core_rst_n_out;
  logic               seq_busy;
  logic [NUM_SRC-1:0] rst_cause;
  logic               por_flag;
  logic               seq_err;

  modport master (
    output rst_req, sys_rst_status, core_rst_status, rst_cause_clr,
    input  sys_rst_n_out, core_rst_n_out, seq_busy, rst_cause, por_flag, seq_err
  );

  modport slave (
    input  rst_req, sys_rst_status, core_rst_status, rst_cause_clr,
    output sys_rst_n_out, core_rst_n_out, seq_busy, rst_cause, por_flag, seq_err
  );
endinterface

// File: rtl/scr1_reset_seq_ctrl_cnt.sv
// rtl/scr1_reset_seq_ctrl_cnt.sv - loadable saturating down-counter
//
// Purpose: single countdown shared by the hold, stage-gap and timeout phases.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (counter -> 0)
//   i_load     load i_load_val (has priority over i_dec)
//   i_load_val value to load
//   i_dec      decrement; holds at zero
//   o_is_zero  counter equals zero
module scr1_rst_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_is_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_is_zero = (r_cnt == '0);

endmodule

// File: rtl/scr1_reset_seq_ctrl.sv
// rtl/scr1_reset_seq_ctrl.sv - staged system/core reset sequencer
//
// Purpose: merges synchronised reset requests, releases the system reset after a
//          quiet hold period, then the core reset after the system buffer cell
//          acknowledges and a fixed gap; records a sticky reset cause.
// Optional: define SCR1_RST_SEQ_TIMEOUT_EN to bound both status waits by TIMEOUT
//          cycles (restart + sticky seq_err on expiry); otherwise seq_err is 0.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  scr1_reset_seq_ctrl_if.slave (requests, status feedback, staged resets,
//        busy, sticky cause / por_flag / seq_err); all outputs are flops
module scr1_reset_seq_ctrl
  import scr1_rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int NUM_SRC     = 4,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT     = 64
) (
  input logic                  clk,
  input logic                  rst,
  scr1_reset_seq_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_GAP_LD  = CNT_W'(STAGE_GAP - 1);
`ifdef SCR1_RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LP_TMO_LD  = CNT_W'(TIMEOUT - 1);
`endif

  type_scr1_rst_seq_state_e r_state;
  type_scr1_rst_seq_state_e w_state_nxt;

  logic               r_sys_n;
  logic               r_core_n;
  logic               r_busy;
  logic [NUM_SRC-1:0] r_cause;
  logic               r_por;

  logic               w_req_any;
  logic               w_released;
  logic               w_clr_ok;
  logic               w_ld;
  logic [CNT_W-1:0]   w_ld_val;
  logic               w_dec;
  logic               w_cnt_zero;
  logic               w_err_set;

  assign w_req_any  = |bus.rst_req;
  assign w_clr_ok   = bus.rst_cause_clr && (r_state == ST_RUN);
  // System reset already released: a new request restarts the whole sequence
  assign w_released = (r_state == ST_WAIT_SYS) || (r_state == ST_GAP) ||
                      (r_state == ST_WAIT_CORE) || (r_state == ST_RUN);

  scr1_rst_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .i_dec      (w_dec),
    .o_is_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ASSERT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_ld_val    = '0;
    w_dec       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_ASSERT: begin
        w_state_nxt = ST_HOLD;
        w_ld        = 1'b1;
        w_ld_val    = LP_HOLD_LD;
      end
      ST_HOLD: begin
        if (w_req_any) begin
          w_ld     = 1'b1;
          w_ld_val = LP_HOLD_LD;
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_WAIT_SYS;
`ifdef SCR1_RST_SEQ_TIMEOUT_EN
          w_ld     = 1'b1;
          w_ld_val = LP_TMO_LD;
`endif
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_WAIT_SYS: begin
        if (bus.sys_rst_status) begin
          w_state_nxt = ST_GAP;
          w_ld        = 1'b1;
          w_ld_val    = LP_GAP_LD;
        end
`ifdef SCR1_RST_SEQ_TIMEOUT_EN
        else if (w_cnt_zero) begin
          w_state_nxt = ST_ASSERT;
          w_err_set   = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_WAIT_CORE;
`ifdef SCR1_RST_SEQ_TIMEOUT_EN
          w_ld     = 1'b1;
          w_ld_val = LP_TMO_LD;
`endif
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_WAIT_CORE: begin
        if (bus.core_rst_status) begin
          w_state_nxt = ST_RUN;
        end
`ifdef SCR1_RST_SEQ_TIMEOUT_EN
        else if (w_cnt_zero) begin
          w_state_nxt = ST_ASSERT;
          w_err_set   = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
`endif
      end
      ST_RUN: begin
        // Status drops here are downstream faults, not requests: ignored
      end
      default: begin
        w_state_nxt = ST_ASSERT;
      end
    endcase
    // A request after system release overrides whatever the phase was doing
    if (w_req_any && w_released) begin
      w_state_nxt = ST_ASSERT;
      w_ld        = 1'b0;
      w_dec       = 1'b0;
      w_err_set   = 1'b0;
    end
  end

  // Outputs are registered copies decoded from the next state, so they change
  // on the same edge as the state and have no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sys_n  <= 1'b0;
      r_core_n <= 1'b0;
      r_busy   <= 1'b1;
      r_cause  <= '0;
      r_por    <= 1'b1;
    end else begin
      r_sys_n  <= (w_state_nxt == ST_WAIT_SYS) || (w_state_nxt == ST_GAP) ||
                  (w_state_nxt == ST_WAIT_CORE) || (w_state_nxt == ST_RUN);
      r_core_n <= (w_state_nxt == ST_WAIT_CORE) || (w_state_nxt == ST_RUN);
      r_busy   <= (w_state_nxt != ST_RUN);
      // New requests win over a simultaneous clear
      r_cause  <= (w_clr_ok ? '0 : r_cause) | bus.rst_req;
      if (w_clr_ok) begin
        r_por <= 1'b0;
      end
    end
  end

`ifdef SCR1_RST_SEQ_TIMEOUT_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (w_clr_ok) begin
      r_err <= 1'b0;
    end
  end

  assign bus.seq_err = r_err;
`else
  // Constant 0 for every legal TIMEOUT; no timeout logic in this build
  assign bus.seq_err = (TIMEOUT < 0);
`endif

  assign bus.sys_rst_n_out  = r_sys_n;
  assign bus.core_rst_n_out = r_core_n;
  assign bus.seq_busy       = r_busy;
  assign bus.rst_cause      = r_cause;
  assign bus.por_flag       = r_por;

endmodule
